// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory geometry, loader framing constants, loader state encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 14;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = 12;
  localparam int unsigned TIMEOUT   = 1000;
  localparam logic [7:0]  SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_HI  = 3'd1,
    CNT_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHK     = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } ld_state_e;

endpackage

// File: rtl/prog_rom_loader.sv
// Host byte-stream to program-memory writer: frames bytes into 14-bit words,
// writes them sequentially and holds the CPU in reset while a load is pending.
module prog_rom_loader
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] rom_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned TO_W      = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;
  localparam int unsigned WHI_W     = DATA_W - BYTE_W;

  ld_state_e            state_q, state_d;
  logic [BYTE_W-1:0]    chk_q, chk_d;
  logic [3:0]           cnt_hi_q, cnt_hi_d;
  logic [WHI_W-1:0]     whi_q, whi_d;
  logic [CNT_W-1:0]     words_q, words_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [TO_W-1:0]      idle_q, idle_d;
  logic                 in_ready_q, in_ready_d;
  logic                 rom_we_q, rom_we_d;
  logic [ADDR_W-1:0]    rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]    rom_wdata_q, rom_wdata_d;
  logic                 cpu_hold_q, cpu_hold_d;
  logic                 load_done_q, load_done_d;
  logic                 load_err_q, load_err_d;

  logic                 accept;
  logic                 timed;
  logic [CNT_W-1:0]     n_words;

  assign accept  = in_valid & in_ready_q;
  assign n_words = {cnt_hi_q, in_data};
  assign timed   = (state_q == CNT_HI) || (state_q == CNT_LO) || (state_q == DATA_HI) ||
                   (state_q == DATA_LO) || (state_q == CHK);

  // Next-state, framing datapath, timeout and registered-output computation.
  always_comb begin
    state_d     = state_q;
    chk_d       = chk_q;
    cnt_hi_d    = cnt_hi_q;
    whi_d       = whi_q;
    words_d     = words_q;
    addr_d      = addr_q;
    idle_d      = '0;
    in_ready_d  = 1'b0;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;

    case (state_q)
      IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d    = CNT_HI;
          cpu_hold_d = 1'b1;
          load_err_d = 1'b0;
          chk_d      = '0;
          addr_d     = '0;
        end
      end
      CNT_HI: begin
        if (accept) begin
          cnt_hi_d = in_data[3:0];
          chk_d    = chk_q + in_data;
          state_d  = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          chk_d   = chk_q + in_data;
          words_d = n_words;
          if ((CNT_W + 1)'(n_words) > (CNT_W + 1)'(MAX_WORDS)) begin
            state_d = ERROR;
          end else if (n_words == '0) begin
            state_d = CHK;
          end else begin
            state_d = DATA_HI;
          end
        end
      end
      DATA_HI: begin
        if (accept) begin
          whi_d   = in_data[WHI_W-1:0];
          chk_d   = chk_q + in_data;
          state_d = DATA_LO;
        end
      end
      DATA_LO: begin
        if (accept) begin
          chk_d       = chk_q + in_data;
          rom_we_d    = 1'b1;
          rom_addr_d  = addr_q;
          rom_wdata_d = {whi_q, in_data};
          addr_d      = addr_q + 1'b1;
          words_d     = words_q - 1'b1;
          state_d     = (words_q == CNT_W'(1)) ? CHK : DATA_HI;
        end
      end
      CHK: begin
        if (accept) begin
          state_d = (in_data == chk_q) ? DONE : ERROR;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Idle-gap watchdog inside a frame; the rom_we bubble counts as an idle cycle.
    if (timed && !accept) begin
      idle_d = idle_q + 1'b1;
      if (idle_d == TO_W'(TIMEOUT_CYC)) begin
        state_d = ERROR;
      end
    end

    if ((state_d == DONE) && (state_q != DONE)) begin
      load_done_d = 1'b1;
      cpu_hold_d  = 1'b0;
    end
    if (state_d == ERROR) begin
      load_err_d = 1'b1;
    end

    in_ready_d = (state_d != DONE) && (state_d != ERROR) && !rom_we_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      chk_q       <= '0;
      cnt_hi_q    <= '0;
      whi_q       <= '0;
      words_q     <= '0;
      addr_q      <= '0;
      idle_q      <= '0;
      in_ready_q  <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      chk_q       <= chk_d;
      cnt_hi_q    <= cnt_hi_d;
      whi_q       <= whi_d;
      words_q     <= words_d;
      addr_q      <= addr_d;
      idle_q      <= idle_d;
      in_ready_q  <= in_ready_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_rom_loader.sv
// Directed bench for prog_rom_loader: per-byte vector table plus hand sequences
// for timeout, mid-frame reset and a gapped 16-word frame.
module tb_prog_rom_loader;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  prog_rom_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]        b;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              done;
    logic              err;
    logic              hold;
  } vec_t;

  vec_t              vq[$];
  int                checks   = 0;
  int                failures = 0;
  int                wr_cnt   = 0;
  logic [ADDR_W-1:0] wr_addr[$];
  logic [DATA_W-1:0] wr_data[$];

  // Write monitor: records every strobe seen on the falling edge.
  always @(negedge clk) begin
    if (!reset && rom_we) begin
      wr_cnt++;
      wr_addr.push_back(rom_addr);
      wr_data.push_back(rom_wdata);
    end
  end

  function automatic vec_t v(input logic [7:0] b, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic dn, input logic er,
                             input logic hd);
    vec_t r;
    r.b = b; r.we = we; r.addr = a; r.wdata = d; r.done = dn; r.err = er; r.hold = hd;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Present one byte from a falling edge, wait (bounded) for acceptance, return #1 after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_wait", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    send_byte(b);
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      send_byte(vq[i].b);
      check($sformatf("v%0d_we", i), {31'b0, rom_we}, {31'b0, vq[i].we});
      if (vq[i].we) begin
        check($sformatf("v%0d_addr", i), 32'(rom_addr), 32'(vq[i].addr));
        check($sformatf("v%0d_wdata", i), 32'(rom_wdata), 32'(vq[i].wdata));
      end
      check($sformatf("v%0d_done", i), {31'b0, load_done}, {31'b0, vq[i].done});
      check($sformatf("v%0d_err", i), {31'b0, load_err}, {31'b0, vq[i].err});
      check($sformatf("v%0d_hold", i), {31'b0, cpu_hold}, {31'b0, vq[i].hold});
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
    check({tag, "_we"}, {31'b0, rom_we}, 32'd0);
    check({tag, "_addr"}, 32'(rom_addr), 32'd0);
    check({tag, "_wdata"}, 32'(rom_wdata), 32'd0);
    check({tag, "_hold"}, {31'b0, cpu_hold}, 32'd0);
    check({tag, "_done"}, {31'b0, load_done}, 32'd0);
    check({tag, "_err"}, {31'b0, load_err}, 32'd0);
  endtask

  initial begin
    int                snap;
    logic [DATA_W-1:0] words[16];
    logic [7:0]        hi_b;
    logic [7:0]        lo_b;
    logic [7:0]        sum;

    // Test 1: two-word frame, checksum 00+02+30+55+0D+8D = 0x21.
    vq.push_back(v(8'hA5, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h00, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h02, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h30, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h55, 1, 11'd0, 14'h3055, 0, 0, 1));
    vq.push_back(v(8'h0D, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h8D, 1, 11'd1, 14'h0D8D, 0, 0, 1));
    vq.push_back(v(8'h21, 0, 0, 0, 1, 0, 0));
    // Test 2: same frame, bad checksum.
    vq.push_back(v(8'hA5, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h00, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h02, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h30, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h55, 1, 11'd0, 14'h3055, 0, 0, 1));
    vq.push_back(v(8'h0D, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h8D, 1, 11'd1, 14'h0D8D, 0, 0, 1));
    vq.push_back(v(8'h00, 0, 0, 0, 0, 1, 1));
    // Test 3: empty frame clears the error and releases hold.
    vq.push_back(v(8'hA5, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h00, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h00, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h00, 0, 0, 0, 1, 0, 0));
    // Test 4: N = 2049 is rejected at CNT_LO.
    vq.push_back(v(8'hA5, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h08, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h01, 0, 0, 0, 0, 1, 1));
    // Non-sync byte in IDLE is dropped; then a frame left hanging for the timeout test.
    vq.push_back(v(8'h12, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(8'hA5, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h00, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h01, 0, 0, 0, 0, 0, 1));
    vq.push_back(v(8'h30, 0, 0, 0, 0, 0, 1));

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", {31'b0, in_ready}, 32'd1);

    apply_range(0, 19);
    check("writes_t1_t3", 32'(wr_cnt), 32'd4);
    snap = wr_cnt;
    apply_range(20, 22);
    check("no_write_t4", 32'(wr_cnt), 32'(snap));
    apply_range(23, vq.size() - 1);

    // Test 5a: idle gap inside a frame; error on the TIMEOUT-th idle cycle.
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("timeout_early", {31'b0, load_err}, 32'd0);
    @(posedge clk);
    #1;
    check("timeout_err", {31'b0, load_err}, 32'd1);
    check("timeout_hold", {31'b0, cpu_hold}, 32'd1);

    // Test 5b: reset in the middle of a frame.
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset = 1'b0;

    // Test 6: 16-word frame with random inter-byte gaps.
    wr_addr.delete();
    wr_data.delete();
    sum = 8'h00 + 8'h10;
    send_gap(8'hA5, $urandom_range(0, 6));
    send_gap(8'h00, $urandom_range(0, 6));
    send_gap(8'h10, $urandom_range(0, 6));
    for (int i = 0; i < 16; i++) begin
      words[i] = 14'($urandom);
      hi_b = {2'($urandom), words[i][13:8]};
      lo_b = words[i][7:0];
      sum  = sum + hi_b + lo_b;
      send_gap(hi_b, $urandom_range(0, 6));
      send_gap(lo_b, $urandom_range(0, 6));
    end
    send_gap(sum, $urandom_range(0, 6));
    check("t6_done", {31'b0, load_done}, 32'd1);
    check("t6_hold", {31'b0, cpu_hold}, 32'd0);
    check("t6_err", {31'b0, load_err}, 32'd0);
    @(posedge clk);
    #1;
    check("t6_done_pulse", {31'b0, load_done}, 32'd0);
    check("t6_nwrites", 32'(wr_addr.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < wr_addr.size()) begin
        check($sformatf("t6_addr%0d", i), 32'(wr_addr[i]), 32'(i));
        check($sformatf("t6_data%0d", i), 32'(wr_data[i]), 32'(words[i]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
